// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned MDU_TIMEOUT = 63;
    localparam int unsigned MDU_CNT_W   = 6;
    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic flush_IFID;
        logic flush_IDEX;
        logic hold_EX;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-facing signal bundle of pipe_ctrl: hazard inputs, control and status outputs.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; ();

    logic [4:0]             rs1_ID;
    logic [4:0]             rs2_ID;
    logic                   use_rs1_ID;
    logic                   use_rs2_ID;
    logic [4:0]             rd_EX;
    logic                   memread_EX;
    logic                   branch_taken_EX;
    logic                   mdu_start_EX;
    logic                   mdu_done;
    logic                   dmem_stall;
    logic                   stall_clr;

    logic                   pc_write;
    logic                   ifid_write;
    logic                   flush_IFID;
    logic                   flush_IDEX;
    logic                   hold_EX;
    logic [1:0]             state;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   mdu_timeout;

    modport master (
        output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, memread_EX,
               branch_taken_EX, mdu_start_EX, mdu_done, dmem_stall, stall_clr,
        input  pc_write, ifid_write, flush_IFID, flush_IDEX, hold_EX,
               state, stall_cnt, mdu_timeout
    );

    modport slave (
        input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, memread_EX,
               branch_taken_EX, mdu_start_EX, mdu_done, dmem_stall, stall_clr,
        output pc_write, ifid_write, flush_IFID, flush_IDEX, hold_EX,
               state, stall_cnt, mdu_timeout
    );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load target.
module pipe_hazard_detect (
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1_ID,
    input  logic       use_rs2_ID,
    input  logic [4:0] rd_EX,
    input  logic       memread_EX,
    output logic       load_use
);

    always_comb begin
        load_use = memread_EX && (rd_EX != '0) &&
                   ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                    (use_rs2_ID && (rs2_ID == rd_EX)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: priority stall/flush mux, multi-cycle MDU wait FSM with timeout, stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);

    state_e                 state_q, state_d;
    logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   mdu_timeout_q, mdu_timeout_d;
    logic                   load_use;
    ctrl_t                  ctrl;

    pipe_hazard_detect u_hazard (
        .rs1_ID     (bus.rs1_ID),
        .rs2_ID     (bus.rs2_ID),
        .use_rs1_ID (bus.use_rs1_ID),
        .use_rs2_ID (bus.use_rs2_ID),
        .rd_EX      (bus.rd_EX),
        .memread_EX (bus.memread_EX),
        .load_use   (load_use)
    );

    // Reset is part of the output priority so the pipeline sees bubbles while held.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            ctrl.flush_IFID = 1'b1;
            ctrl.flush_IDEX = 1'b1;
        end else if (bus.dmem_stall) begin
            ctrl.hold_EX = 1'b1;
        end else if (state_q == MDU_WAIT || bus.mdu_start_EX) begin
            ctrl.hold_EX = 1'b1;
        end else if (bus.branch_taken_EX) begin
            ctrl.pc_write   = 1'b1;
            ctrl.ifid_write = 1'b1;
            ctrl.flush_IFID = 1'b1;
            ctrl.flush_IDEX = 1'b1;
        end else if (load_use) begin
            ctrl.flush_IDEX = 1'b1;
        end else begin
            ctrl.pc_write   = 1'b1;
            ctrl.ifid_write = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        mdu_cnt_d     = mdu_cnt_q;
        mdu_timeout_d = mdu_timeout_q;
        stall_cnt_d   = stall_cnt_q;

        case (state_q)
            RUN: begin
                if (bus.mdu_start_EX) begin
                    state_d   = MDU_WAIT;
                    mdu_cnt_d = '0;
                end
            end
            MDU_WAIT: begin
                if (bus.mdu_done) begin
                    state_d = RUN;
                end else begin
                    mdu_cnt_d = mdu_cnt_q + MDU_CNT_W'(1);
                    if (mdu_cnt_d == MDU_CNT_W'(MDU_TIMEOUT)) begin
                        mdu_timeout_d = 1'b1;
                        state_d       = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        if (bus.stall_clr) begin
            stall_cnt_d = '0;
        end else if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            mdu_cnt_q     <= '0;
            stall_cnt_q   <= '0;
            mdu_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mdu_cnt_q     <= mdu_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            mdu_timeout_q <= mdu_timeout_d;
        end
    end

    assign bus.pc_write    = ctrl.pc_write;
    assign bus.ifid_write  = ctrl.ifid_write;
    assign bus.flush_IFID  = ctrl.flush_IFID;
    assign bus.flush_IDEX  = ctrl.flush_IDEX;
    assign bus.hold_EX     = ctrl.hold_EX;
    assign bus.state       = state_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.mdu_timeout = mdu_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/MDU/reset scenarios plus random traffic against a cycle model.
module tb_pipe_ctrl;

    logic clk;
    logic reset;
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state: outstanding MDU op, cycles waited, stall count, sticky timeout.
    bit          m_busy;
    int unsigned m_wait;
    int unsigned m_stalls;
    bit          m_tmo;

    pipe_ctrl_if ifc ();

    pipe_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(ifc.mdu_start_EX && ifc.branch_taken_EX))
            else $error("protocol error: mdu_start_EX with branch_taken_EX");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {pc_write, ifid_write, flush_IFID, flush_IDEX, hold_EX}.
    function automatic logic [4:0] exp_ctrl();
        logic hit;
        hit = ifc.memread_EX && (ifc.rd_EX != 5'd0) &&
              ((ifc.use_rs1_ID && ifc.rs1_ID == ifc.rd_EX) ||
               (ifc.use_rs2_ID && ifc.rs2_ID == ifc.rd_EX));
        if (!reset)                          return 5'b00110;
        if (ifc.dmem_stall)                  return 5'b00001;
        if (m_busy || ifc.mdu_start_EX)      return 5'b00001;
        if (ifc.branch_taken_EX)             return 5'b11110;
        if (hit)                             return 5'b00010;
        return 5'b11000;
    endfunction

    task automatic idle();
        ifc.rs1_ID = 5'd0;  ifc.rs2_ID = 5'd0;
        ifc.use_rs1_ID = 1'b0; ifc.use_rs2_ID = 1'b0;
        ifc.rd_EX = 5'd0;   ifc.memread_EX = 1'b0;
        ifc.branch_taken_EX = 1'b0; ifc.mdu_start_EX = 1'b0;
        ifc.mdu_done = 1'b0; ifc.dmem_stall = 1'b0; ifc.stall_clr = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic [4:0] e;
        #1;
        if (!reset) begin
            m_busy = 1'b0; m_wait = 0; m_stalls = 0; m_tmo = 1'b0;
        end
        e = exp_ctrl();
        check("pc_write",    32'(ifc.pc_write),    32'(e[4]));
        check("ifid_write",  32'(ifc.ifid_write),  32'(e[3]));
        check("flush_IFID",  32'(ifc.flush_IFID),  32'(e[2]));
        check("flush_IDEX",  32'(ifc.flush_IDEX),  32'(e[1]));
        check("hold_EX",     32'(ifc.hold_EX),     32'(e[0]));
        check("state",       32'(ifc.state),       m_busy ? 32'd1 : 32'd0);
        check("stall_cnt",   32'(ifc.stall_cnt),   m_stalls);
        check("mdu_timeout", 32'(ifc.mdu_timeout), 32'(m_tmo));
        @(posedge clk);
        if (reset) begin
            if (ifc.stall_clr)                  m_stalls = 0;
            else if (!e[4] && m_stalls < 65535) m_stalls++;
            if (!m_busy) begin
                if (ifc.mdu_start_EX) begin
                    m_busy = 1'b1;
                    m_wait = 0;
                end
            end else if (ifc.mdu_done) begin
                m_busy = 1'b0;
            end else begin
                m_wait++;
                if (m_wait == 63) begin
                    m_tmo  = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_stalls();
        idle();
        ifc.stall_clr = 1'b1;
        step();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        m_busy = 1'b0; m_wait = 0; m_stalls = 0; m_tmo = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        step();
        check("rst_flushes", {30'd0, ifc.flush_IFID, ifc.flush_IDEX}, 32'd3);
        reset = 1'b1;

        // Load-use on rs2: exactly one bubble.
        ifc.memread_EX = 1'b1; ifc.rd_EX = 5'd5; ifc.rs2_ID = 5'd5; ifc.use_rs2_ID = 1'b1;
        step();
        idle();
        step();
        check("lu_stall_cnt", 32'(ifc.stall_cnt), 32'd1);
        check("lu_released",  32'(ifc.pc_write),  32'd1);

        // No hazard when rd is x0 or rs2 is not read.
        ifc.memread_EX = 1'b1; ifc.rd_EX = 5'd0; ifc.rs2_ID = 5'd0; ifc.use_rs2_ID = 1'b1;
        step();
        ifc.rd_EX = 5'd5; ifc.rs2_ID = 5'd5; ifc.use_rs2_ID = 1'b0;
        step();
        // Branch beats load-use.
        ifc.use_rs2_ID = 1'b1; ifc.branch_taken_EX = 1'b1;
        step();
        check("br_stall_cnt", 32'(ifc.stall_cnt), 32'd1);

        // MDU op, done on the 10th wait cycle: 11 frozen cycles.
        clear_stalls();
        ifc.mdu_start_EX = 1'b1;
        step();
        idle();
        repeat (9) step();
        ifc.mdu_done = 1'b1;
        step();
        idle();
        check("mdu_state",  32'(ifc.state),     32'd0);
        check("mdu_stalls", 32'(ifc.stall_cnt), 32'd11);
        step();

        // MDU op that never completes: timeout after 63 wait cycles.
        clear_stalls();
        ifc.mdu_start_EX = 1'b1;
        step();
        idle();
        repeat (62) step();
        check("tmo_pre_state", 32'(ifc.state),       32'd1);
        check("tmo_pre_flag",  32'(ifc.mdu_timeout), 32'd0);
        step();
        check("tmo_state", 32'(ifc.state),       32'd0);
        check("tmo_flag",  32'(ifc.mdu_timeout), 32'd1);
        ifc.mdu_start_EX = 1'b1;
        step();
        idle();
        ifc.mdu_done = 1'b1;
        step();
        idle();
        repeat (3) step();
        check("tmo_sticky", 32'(ifc.mdu_timeout), 32'd1);

        // Data stall during a branch freezes without flushing; reset aborts an MDU wait.
        ifc.dmem_stall = 1'b1; ifc.branch_taken_EX = 1'b1;
        step();
        idle();
        ifc.mdu_start_EX = 1'b1;
        step();
        idle();
        repeat (4) step();
        reset = 1'b0;
        step();
        check("rst_state",   32'(ifc.state),       32'd0);
        check("rst_stalls",  32'(ifc.stall_cnt),   32'd0);
        check("rst_timeout", 32'(ifc.mdu_timeout), 32'd0);
        check("rst_flush",   {30'd0, ifc.flush_IFID, ifc.flush_IDEX}, 32'd3);
        reset = 1'b1;
        step();

        // Random traffic; small register range keeps hazard hits frequent.
        for (int i = 0; i < 600; i++) begin
            ifc.rs1_ID          = 5'($urandom_range(0, 3));
            ifc.rs2_ID          = 5'($urandom_range(0, 3));
            ifc.rd_EX           = 5'($urandom_range(0, 3));
            ifc.use_rs1_ID      = 1'($urandom_range(0, 1));
            ifc.use_rs2_ID      = 1'($urandom_range(0, 1));
            ifc.memread_EX      = 1'($urandom_range(0, 1));
            ifc.branch_taken_EX = ($urandom_range(0, 5) == 0);
            ifc.mdu_start_EX    = ($urandom_range(0, 15) == 0);
            if (ifc.mdu_start_EX) ifc.branch_taken_EX = 1'b0;
            ifc.mdu_done        = ($urandom_range(0, 7) == 0);
            ifc.dmem_stall      = ($urandom_range(0, 7) == 0);
            ifc.stall_clr       = ($urandom_range(0, 31) == 0);
            reset               = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports rs1_ID and rs2_ID, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have ports use_rs1_ID and use_rs2_ID, input, 1 bit each: the ID instruction reads rs1/rs2.
REQ-005 SHALL have port rd_EX, input, 5 bits: destination register of the instruction in EX.
REQ-006 SHALL have port memread_EX, input, 1 bit: the EX instruction is a load.
REQ-007 SHALL have port branch_taken_EX, input, 1 bit: branch or jump resolved taken in EX.
REQ-008 SHALL have ports mdu_start_EX and mdu_done, input, 1 bit each: a multi-cycle MUL/DIV starts in EX / the result is ready.
REQ-009 SHALL have port dmem_stall, input, 1 bit: data memory not ready in MEM.
REQ-010 SHALL have port stall_clr, input, 1 bit: synchronous clear of stall_cnt.
REQ-011 SHALL have outputs pc_write, ifid_write, flush_IFID, flush_IDEX, hold_EX, 1 bit each: PC enable, IF/ID enable, IF/ID bubble, ID/EX bubble, and ID/EX hold with EX/MEM bubble.
REQ-012 SHALL have outputs state (2 bits), stall_cnt (16 bits) and mdu_timeout (1 bit, sticky).

Function
REQ-013 SHALL implement FSM states RUN and MDU_WAIT only.
REQ-014 SHALL drive control outputs combinationally; the first matching rule in REQ-015 to REQ-019 applies.
REQ-015 When dmem_stall=1, in any state, SHALL drive pc_write=0, ifid_write=0, hold_EX=1, flush_IFID=0, flush_IDEX=0.
REQ-016 When state=MDU_WAIT, or state=RUN with mdu_start_EX=1, SHALL drive pc_write=0, ifid_write=0, hold_EX=1, with no flushes.
REQ-017 When branch_taken_EX=1, SHALL drive pc_write=1, ifid_write=1, flush_IFID=1, flush_IDEX=1, hold_EX=0; a branch takes priority over load-use.
REQ-018 Load-use hazard: when memread_EX=1, rd_EX!=0, and (use_rs1_ID and rs1_ID==rd_EX) or (use_rs2_ID and rs2_ID==rd_EX), SHALL drive pc_write=0, ifid_write=0, flush_IDEX=1, others 0, giving exactly one bubble.
REQ-019 Otherwise SHALL drive pc_write=1, ifid_write=1, all others 0.
REQ-020 RUN to MDU_WAIT SHALL occur when mdu_start_EX=1, regardless of dmem_stall; mdu_cnt is cleared on entry.
REQ-021 In MDU_WAIT, mdu_done=1 SHALL return the FSM to RUN on the next edge; the release happens one cycle after done, and mdu_done is ignored in RUN.
REQ-022 mdu_cnt (6 bits) SHALL increment each MDU_WAIT cycle without done; reaching 63 SHALL set mdu_timeout=1 and force RUN.
REQ-023 stall_cnt SHALL increment by 1 each cycle pc_write=0 and saturate at 0xFFFF; stall_clr has priority over increment.
REQ-024 mdu_start_EX and branch_taken_EX SHALL never be asserted together; the bench flags it as a protocol error.

Reset
REQ-025 While reset=0, SHALL hold state=RUN, mdu_cnt=0, stall_cnt=0, mdu_timeout=0.
REQ-026 While reset=0, SHALL drive pc_write=0, ifid_write=0, flush_IFID=1, flush_IDEX=1, hold_EX=0.
REQ-027 Reset asserted mid-MDU_WAIT SHALL abort to RUN immediately; the first edge after release behaves per REQ-015 to REQ-019.

Structure
REQ-028 Shared package SHALL hold: state enum (RUN=0, MDU_WAIT=1), MDU_TIMEOUT=63, STALL_CNT_W=16.
REQ-029 Load-use compare SHALL be a combinational sub-module pipe_hazard_detect; the FSM, counters and priority mux stay in pipe_ctrl.

Verification
REQ-030 memread_EX=1, rd_EX=5, rs2_ID=5, use_rs2_ID=1 -> one cycle of pc_write=0, ifid_write=0, flush_IDEX=1; stall_cnt=1.
REQ-031 Same as REQ-030 but rd_EX=0, or use_rs2_ID=0 -> no stall, pc_write=1.
REQ-032 branch_taken_EX=1 together with a load-use hit -> flush_IFID=1, flush_IDEX=1, pc_write=1.
REQ-033 mdu_start_EX pulse, mdu_done after 10 cycles -> 11 frozen cycles with hold_EX=1, state returns to 0, stall_cnt=11.
REQ-034 mdu_start_EX with no done -> mdu_timeout=1 after 63 MDU_WAIT cycles; FSM returns to RUN; timeout stays set until reset.
REQ-035 dmem_stall=1 during a branch, then reset=0 mid-MDU_WAIT -> freeze (no flush) during the stall; reset gives state=0, counters 0, both flushes 1.
